// File: rtl/uart_tx_engine_pkg.sv
// Shared UART definitions: state encodings, default line rate, idle level.
// Also consumed by the receive side; optional parity is selected by UART_TX_PARITY_EN.
package uart_tx_engine_pkg;

    localparam int DEF_CLK_FREQ = 50000000;
    localparam int DEF_BAUD     = 9600;

    localparam logic LINE_IDLE = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tx_band_gen.sv
// Bit-period timer for the UART transmitter: counts 0..BPS_CNT-1 while enabled
// and pulses bit_end_o on the last cycle of each bit.
module tx_band_gen #(
    parameter int BPS_CNT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int               CNT_W    = $clog2(BPS_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART 8N1 transmitter, LSB first, with its own bit timer.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_pin_out,
    output logic       tx_done_sig
);

    localparam int BPS_CNT = CLK_FREQ / BAUD;

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       bit_end;
    logic       accept;
    logic       is_idle;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    assign is_idle     = (state_q == ST_IDLE);
    assign tx_ready    = is_idle;
    assign accept      = is_idle && tx_start;
    assign tx_pin_out  = tx_q;
    assign tx_done_sig = (state_q == ST_STOP) && bit_end;

    tx_band_gen #(
        .BPS_CNT(BPS_CNT)
    ) u_band_gen (
        .clk      (clk),
        .rst      (rst),
        .en_i     (!is_idle),
        .clr_i    (is_idle),
        .bit_end_o(bit_end)
    );

    // Line level is computed one cycle ahead so tx_pin_out is a plain flop output.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d      = LINE_IDLE;
                bit_cnt_d = 3'd0;
                if (accept) begin
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(tx_data);
`endif
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = LINE_IDLE;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    tx_d    = LINE_IDLE;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    tx_d    = LINE_IDLE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = LINE_IDLE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= LINE_IDLE;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine at CLK_FREQ=1000, BAUD=100 (10 cycles per bit).
// Frame-slot reference model plus directed literal checks and random traffic.
module tb_uart_tx_engine;

    localparam int BPS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif
    localparam int FL = NSLOT * BPS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready;
    logic       tx_pin_out;
    logic       tx_done_sig;

    int total = 0;
    int bad   = 0;

    uart_tx_engine #(
        .CLK_FREQ(1000),
        .BAUD    (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .tx_pin_out (tx_pin_out),
        .tx_done_sig(tx_done_sig)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a list of slots, each held BPS cycles.
    function automatic logic slot_value(input logic [7:0] d, input int s);
        if (s == 0) return 1'b0;
        if (s <= 8) return d[s-1];
        if (s == 9 && NSLOT == 11) return ^d;
        return 1'b1;
    endfunction

    logic m_busy = 1'b0;
    int   m_cyc  = 0;
    logic m_bits [0:10];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_cyc  = 0;
        end else if (m_busy) begin
            if (m_cyc == FL) begin
                m_busy = 1'b0;
                m_cyc  = 0;
            end else begin
                m_cyc++;
            end
        end else if (tx_start) begin
            m_busy = 1'b1;
            m_cyc  = 1;
            for (int s = 0; s < 11; s++) m_bits[s] = slot_value(tx_data, s);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!tx_ready && n < 400) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", {31'd0, tx_ready}, 32'd1);
    endtask

    // Sends one byte, checks each slot against a literal pattern, the done cycle
    // and the ready cycle; optionally pulses a competing request mid-frame.
    task automatic directed(input string nm, input logic [7:0] d, input logic [10:0] pat,
                            input int pulse_at, input logic [7:0] pulse_d);
        int hits [11];
        int done_at;
        int ready_at;
        done_at  = -1;
        ready_at = -1;
        for (int s = 0; s < 11; s++) hits[s] = 0;
        wait_idle();
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int c = 1; c <= FL + 1; c++) begin
            if (c == pulse_at) begin
                tx_data  = pulse_d;
                tx_start = 1'b1;
            end else if (c == pulse_at + 1) begin
                tx_start = 1'b0;
            end
            @(negedge clk);
            if (c <= FL && tx_pin_out === pat[(c-1)/BPS]) hits[(c-1)/BPS]++;
            if (tx_done_sig === 1'b1 && done_at < 0) done_at = c;
            if (tx_ready === 1'b1 && ready_at < 0) ready_at = c;
            tick();
        end
        for (int s = 0; s < NSLOT; s++) check($sformatf("%s_slot%0d", nm, s), hits[s], BPS);
        check({nm, "_done_cycle"}, done_at, FL);
        check({nm, "_ready_cycle"}, ready_at, FL + 1);
    endtask

    initial begin
        int pulses;
        int p0;
        int p1;
        int lows;

        #1 rst = 1'b0;
        fork
            forever begin
                @(negedge clk);
                check("line", {31'd0, tx_pin_out}, {31'd0, (m_busy ? m_bits[(m_cyc-1)/BPS] : 1'b1)});
                check("ready", {31'd0, tx_ready}, {31'd0, !m_busy});
                check("done", {31'd0, tx_done_sig}, {31'd0, (m_busy && m_cyc == FL)});
            end
        join_none

        // Reset held with a pending request
        tx_start = 1'b1;
        tx_data  = 8'hAA;
        repeat (15) begin
            @(negedge clk);
            check("rst_line", {31'd0, tx_pin_out}, 32'd1);
            check("rst_ready", {31'd0, tx_ready}, 32'd1);
            check("rst_done", {31'd0, tx_done_sig}, 32'd0);
        end
        tick();
        tx_start = 1'b0;
        rst      = 1'b1;
        repeat (3) tick();

`ifdef UART_TX_PARITY_EN
        directed("b55", 8'h55, 11'b10010101010, -10, 8'h00);
        directed("bA3_busy", 8'hA3, 11'b10101000110, 30, 8'hFF);
`else
        directed("b55", 8'h55, 11'b11010101010, -10, 8'h00);
        directed("bA3_busy", 8'hA3, 11'b11101000110, 30, 8'hFF);
`endif
        directed("b07", 8'h07, 11'b11000001110, -10, 8'h00);
        repeat (3) tick();

        // Back-to-back frames with tx_start held
        wait_idle();
        pulses   = 0;
        p0       = -1;
        p1       = -1;
        tx_data  = 8'h41;
        tx_start = 1'b1;
        tick();
        tx_data = 8'h42;
        for (int c = 1; c <= 2 * FL + 10; c++) begin
            @(negedge clk);
            if (tx_done_sig === 1'b1) begin
                pulses++;
                if (p0 < 0) p0 = c;
                else p1 = c;
            end
            if (c == FL + 1) check("b2b_gap_line", {31'd0, tx_pin_out}, 32'd1);
            if (c == FL + 2) check("b2b_second_start", {31'd0, tx_pin_out}, 32'd0);
            tick();
            if (c == FL + 1) tx_start = 1'b0;
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_spacing", p1 - p0, FL + 1);

        // Reset during a data bit, then during the start bit
        wait_idle();
        tx_data  = 8'h0F;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (44) tick();
        rst = 1'b0;
        #1;
        check("midrst45_line", {31'd0, tx_pin_out}, 32'd1);
        check("midrst45_ready", {31'd0, tx_ready}, 32'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        tx_data  = 8'h0F;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (4) tick();
        check("pre_rst_start_line", {31'd0, tx_pin_out}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst5_line", {31'd0, tx_pin_out}, 32'd1);
        check("midrst5_ready", {31'd0, tx_ready}, 32'd1);
        repeat (2) tick();
        rst  = 1'b1;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_pin_out !== 1'b1) lows++;
            tick();
        end
        check("post_rst_idle_lows", lows, 0);

        // Random traffic, including requests while busy and held starts
        for (int i = 0; i < 1500; i++) begin
            tx_data  = 8'($urandom);
            tx_start = ($urandom_range(0, 2) == 0);
            tick();
        end
        tx_start = 1'b0;
        wait_idle();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- UART transmitter: serialises one byte per request onto the line as 8N1, LSB first.
- Sits upstream of the UART receive path. It drives the serial line that the receiver's H2L detector and receive controller consume.
- Also used for loopback and echo tests on the FPGA board.
- Contains its own bit-period timer, so it does not depend on the receive-side baud generator.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- BPS_CNT, CLK_FREQ/BAUD (localparam, integer division), clock cycles per bit. Must be at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low. Asserted (low) clears all state immediately; deassertion is synchronous to clk.
- tx_data  input  8  byte to send. Sampled only on the accept cycle.
- tx_start  input  1  send request. Level-sensitive; qualified by tx_ready.
- tx_ready  output  1  high when idle and able to accept a byte.
- tx_pin_out  output  1  serial line, registered, idle high.
- tx_done_sig  output  1  one-cycle pulse marking the end of a frame.

Behaviour:
- Reset values: tx_pin_out=1, tx_ready=1, tx_done_sig=0, state=IDLE, bit counter=0, baud counter=0.
- Accept cycle: any cycle where tx_ready=1 and tx_start=1.
  - tx_data is latched into the shift register.
  - tx_ready drops the following cycle.
- tx_start while tx_ready=0 is ignored; the latched byte is unaffected.
- Latency: the start bit (tx_pin_out=0) appears on the clock edge after acceptance.
- Each bit lasts exactly BPS_CNT cycles.
  - Baud counter runs 0..BPS_CNT-1 and wraps; bit_end fires at BPS_CNT-1.
  - Counter width is $clog2(BPS_CNT).
  - Counter is cleared in IDLE.
- State machine:
  - IDLE: line high, tx_ready=1. Go to START on accept.
  - START: line 0 for one bit period, then DATA.
  - DATA: line = shift[0] for each bit; shift right at bit_end. A 3-bit counter 0..7 selects the bit; go to STOP after bit 7 (or PARITY, see Optional Feature).
  - STOP: line 1 for one bit period. tx_done_sig=1 in the last cycle of STOP only, then IDLE.
- Frame length: 10*BPS_CNT cycles from the first start-bit cycle to the end of STOP.
- Back-to-back frames: tx_ready rises the cycle after the tx_done_sig pulse. If tx_start is held high, the next byte is accepted in that cycle, giving exactly one idle-high cycle between frames.
- Reset mid-frame: tx_pin_out goes to 1 asynchronously and the partial frame is abandoned, not resumed. After rst releases the block stays IDLE until a new request.
- tx_pin_out comes straight from a flop, so it is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP for one bit period.
  - Line carries even parity = XOR of the 8 latched data bits.
  - Frame length is 11*BPS_CNT cycles.
- Undefined: no PARITY state and no parity logic; frame is exactly 8N1.

Decomposition:
- Shared include uart_defs.vh:
  - state encodings IDLE/START/DATA/PARITY/STOP (3-bit);
  - default CLK_FREQ and BAUD;
  - line idle level constant;
  - also consumed by the receive side for matching defaults.
- One sub-module, tx_band_gen:
  - baud counter with enable (active when not IDLE) and synchronous clear;
  - outputs a bit_end pulse;
  - same reset style.
- Top-level FSM and shift register live in uart_tx_engine.

Test Plan:
All cases use CLK_FREQ=1000 and BAUD=100, so BPS_CNT=10.
1. Reset: hold rst=0 with tx_start=1 → tx_pin_out=1, tx_ready=1, tx_done_sig=0 throughout. No frame starts until rst=1.
2. Single byte 0x55 → from the edge after accept the line shows 0,1,0,1,0,1,0,1,0,1, each held 10 cycles. tx_done_sig pulses at cycle 100; tx_ready=1 at cycle 101.
3. Busy request: send 0xA3, then pulse tx_start with tx_data=0xFF at cycle 30 → frame bits remain 1,1,0,0,0,1,0,1 (LSB first). 0xFF is never sent.
4. Back-to-back: hold tx_start=1 with 0x41 then 0x42 → two frames separated by exactly one high cycle. Exactly two tx_done_sig pulses, 101 cycles apart.
5. Reset mid-frame: assert rst=0 at cycle 45 of a 0x0F frame → tx_pin_out=1 in the same cycle (async), tx_ready=1. After release, the line stays high with tx_start=0.
6. UART_TX_PARITY_EN defined, byte 0x07 → parity bit=1 held 10 cycles before stop. tx_done_sig fires at cycle 110.
